// File: rtl/gemcsc_seq_pkg.sv
// Shared encodings for the GEM-CSC match sequencer: FSM states, LCT quality codes,
// match_flags bit positions and the sticky-flag record.
package gemcsc_seq_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_OPEN    = 2'd1;
  localparam logic [1:0] ST_RESOLVE = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  localparam logic [2:0] Q_ACC_BEND = 3'd7;
  localparam logic [2:0] Q_ACC      = 3'd6;
  localparam logic [2:0] Q_ACG_BEND = 3'd5;
  localparam logic [2:0] Q_ACG      = 3'd4;
  localparam logic [2:0] Q_AC       = 3'd3;
  localparam logic [2:0] Q_AC2      = 3'd2;
  localparam logic [2:0] Q_CC       = 3'd1;
  localparam logic [2:0] Q_NONE     = 3'd0;

  localparam int MF_ALCT_COPAD      = 0;
  localparam int MF_CLCT_COPAD      = 1;
  localparam int MF_ALCT_CLCT       = 2;
  localparam int MF_ALCT_CLCT_GEM   = 3;
  localparam int MF_ALCT_CLCT_COPAD = 4;

  typedef struct packed {
    logic alct;
    logic clct;
    logic gem;
    logic copad;
  } sticky_t;

  function automatic logic [4:0] match_from_sticky(input sticky_t s);
    logic [4:0] m;
    m = '0;
    m[MF_ALCT_CLCT_COPAD] = s.alct & s.clct & s.copad;
    m[MF_ALCT_CLCT_GEM]   = s.alct & s.clct & s.gem;
    m[MF_ALCT_CLCT]       = s.alct & s.clct;
    m[MF_CLCT_COPAD]      = s.clct & s.copad;
    m[MF_ALCT_COPAD]      = s.alct & s.copad;
    return m;
  endfunction

endpackage

// File: rtl/gemcsc_quality_encode.sv
// Combinational priority encoder: 5 match bits plus GEM-CSC bend enable to 3-bit LCT quality.
// Also intended for reuse by the LCT builder.
module gemcsc_quality_encode
  import gemcsc_seq_pkg::*;
(
  input  logic [4:0] match_bits,
  input  logic       bend_en,
  output logic [2:0] quality
);

  // clct_copad outranks alct_copad even though its code is numerically lower.
  always_comb begin
    quality = Q_NONE;
    if (match_bits[MF_ALCT_CLCT_COPAD])    quality = bend_en ? Q_ACC_BEND : Q_ACC;
    else if (match_bits[MF_ALCT_CLCT_GEM]) quality = bend_en ? Q_ACG_BEND : Q_ACG;
    else if (match_bits[MF_ALCT_CLCT])     quality = Q_AC;
    else if (match_bits[MF_CLCT_COPAD])    quality = Q_CC;
    else if (match_bits[MF_ALCT_COPAD])    quality = Q_AC2;
  end

endmodule

// File: rtl/gemcsc_match_sequencer.sv
// GEM-CSC match sequencer for one chamber: window -> resolve -> hold under valid/ack.
// Optional build macro GEMCSC_EARLY_CLOSE_EN closes the window once ALCT+CLCT+copad are all seen.
module gemcsc_match_sequencer
  import gemcsc_seq_pkg::*;
#(
  parameter int MXWIN   = 7,
  parameter int MXDROPB = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               alct_vpf,
  input  logic               clct_vpf,
  input  logic               gem_vpf,
  input  logic               copad_vpf,
  input  logic               gemcsc_bend_enable,
  input  logic               lct_ack,
  output logic               lct_vpf,
  output logic [2:0]         lct_q,
  output logic [4:0]         match_flags,
  output logic               seq_busy,
  output logic [MXDROPB-1:0] drop_cnt,
  output logic [1:0]         seq_state
);

  // Handshake: lct_vpf rises with a resolved nonzero quality and stays high with lct_q and
  // match_flags frozen until lct_ack is sampled high on a clock edge; ack is ignored otherwise.

  localparam logic [3:0] WIN_LAST = 4'(MXWIN - 1);

  logic [1:0] state, state_nxt;
  sticky_t    sticky, hits;
  logic [3:0] win_cnt;
  logic       trig, drop, window_done;
  logic [4:0] match_now;
  logic [2:0] q_now;

  assign trig = alct_vpf | clct_vpf | copad_vpf;
  assign hits = '{alct: alct_vpf, clct: clct_vpf, gem: gem_vpf, copad: copad_vpf};
  assign drop = trig & ((state == ST_RESOLVE) | (state == ST_HOLD));

`ifdef GEMCSC_EARLY_CLOSE_EN
  logic best_seen;
  assign best_seen = (sticky.alct | alct_vpf) & (sticky.clct | clct_vpf) & (sticky.copad | copad_vpf);
  assign window_done = (win_cnt == WIN_LAST) | best_seen;
`else
  assign window_done = (win_cnt == WIN_LAST);
`endif

  assign match_now = match_from_sticky(sticky);

  gemcsc_quality_encode u_quality (
    .match_bits (match_now),
    .bend_en    (gemcsc_bend_enable),
    .quality    (q_now)
  );

  assign seq_busy  = (state != ST_IDLE);
  assign seq_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (trig) state_nxt = (MXWIN == 1) ? ST_RESOLVE : ST_OPEN;
      ST_OPEN:    if (window_done) state_nxt = ST_RESOLVE;
      ST_RESOLVE: state_nxt = (q_now != Q_NONE) ? ST_HOLD : ST_IDLE;
      ST_HOLD:    if (lct_ack) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      sticky      <= '0;
      win_cnt     <= '0;
      lct_vpf     <= 1'b0;
      lct_q       <= Q_NONE;
      match_flags <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (trig) begin
            sticky  <= hits;
            win_cnt <= 4'd1;
          end
        end
        ST_OPEN: begin
          sticky  <= sticky | hits;
          win_cnt <= win_cnt + 4'd1;
        end
        ST_RESOLVE: begin
          if (q_now != Q_NONE) begin
            lct_vpf     <= 1'b1;
            lct_q       <= q_now;
            match_flags <= match_now;
          end else begin
            sticky  <= '0;
            win_cnt <= '0;
          end
        end
        ST_HOLD: begin
          if (lct_ack) begin
            lct_vpf     <= 1'b0;
            lct_q       <= Q_NONE;
            match_flags <= '0;
            sticky      <= '0;
            win_cnt     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_gemcsc_match_sequencer.sv
// Directed plus randomized bench for gemcsc_match_sequencer, checked against a
// window-level reference model; honours GEMCSC_EARLY_CLOSE_EN when defined.
module tb_gemcsc_match_sequencer;

  localparam int MXWIN = 7;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       alct_vpf = 1'b0, clct_vpf = 1'b0, gem_vpf = 1'b0, copad_vpf = 1'b0;
  logic       gemcsc_bend_enable = 1'b0, lct_ack = 1'b0;

  logic       lct_vpf, seq_busy;
  logic [2:0] lct_q;
  logic [4:0] match_flags;
  logic [7:0] drop_cnt;
  logic [1:0] seq_state;

  logic       lct_vpf_d4, seq_busy_d4;
  logic [2:0] lct_q_d4;
  logic [4:0] match_flags_d4;
  logic [3:0] drop_cnt_d4;
  logic [1:0] seq_state_d4;

  int checks = 0;
  int errors = 0;
  int exp_drop = 0;

  logic bx_a[0:14], bx_c[0:14], bx_g[0:14], bx_p[0:14];

  gemcsc_match_sequencer #(.MXWIN(MXWIN), .MXDROPB(8)) dut (
    .clock(clock), .reset_n(reset_n), .alct_vpf(alct_vpf), .clct_vpf(clct_vpf),
    .gem_vpf(gem_vpf), .copad_vpf(copad_vpf), .gemcsc_bend_enable(gemcsc_bend_enable),
    .lct_ack(lct_ack), .lct_vpf(lct_vpf), .lct_q(lct_q), .match_flags(match_flags),
    .seq_busy(seq_busy), .drop_cnt(drop_cnt), .seq_state(seq_state)
  );

  gemcsc_match_sequencer #(.MXWIN(MXWIN), .MXDROPB(4)) dut_d4 (
    .clock(clock), .reset_n(reset_n), .alct_vpf(alct_vpf), .clct_vpf(clct_vpf),
    .gem_vpf(gem_vpf), .copad_vpf(copad_vpf), .gemcsc_bend_enable(gemcsc_bend_enable),
    .lct_ack(lct_ack), .lct_vpf(lct_vpf_d4), .lct_q(lct_q_d4), .match_flags(match_flags_d4),
    .seq_busy(seq_busy_d4), .drop_cnt(drop_cnt_d4), .seq_state(seq_state_d4)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  function automatic logic [2:0] ref_q(input logic a, input logic c, input logic g,
                                       input logic p, input logic b);
    if (a && c && p) return b ? 3'd7 : 3'd6;
    if (a && c && g) return b ? 3'd5 : 3'd4;
    if (a && c)      return 3'd3;
    if (c && p)      return 3'd1;
    if (a && p)      return 3'd2;
    return 3'd0;
  endfunction

  task automatic idle_inputs();
    alct_vpf = 1'b0; clct_vpf = 1'b0; gem_vpf = 1'b0; copad_vpf = 1'b0;
    lct_ack = 1'b0; gemcsc_bend_enable = 1'b0;
  endtask

  task automatic clear_bx();
    for (int k = 0; k < 15; k++) begin
      bx_a[k] = 1'b0; bx_c[k] = 1'b0; bx_g[k] = 1'b0; bx_p[k] = 1'b0;
    end
  endtask

  task automatic chk_drops(input string tag);
    chk({tag, "_drop"}, 32'(drop_cnt), 32'(sat(exp_drop, 255)));
    chk({tag, "_drop_d4"}, 32'(drop_cnt_d4), 32'(sat(exp_drop, 15)));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vpf"}, 32'(lct_vpf), 32'd0);
    chk({tag, "_q"}, 32'(lct_q), 32'd0);
    chk({tag, "_flags"}, 32'(match_flags), 32'd0);
    chk({tag, "_busy"}, 32'(seq_busy), 32'd0);
    chk({tag, "_drop"}, 32'(drop_cnt), 32'd0);
    chk({tag, "_drop_d4"}, 32'(drop_cnt_d4), 32'd0);
  endtask

  // Drives one trigger window from bx_* (bx 0 must carry a trigger), then RESOLVE,
  // HOLD for hold_cycles, then ack. drop_mode: 0 none, 1 random, 2 every HOLD cycle.
  task automatic drop_inputs(input logic r);
    int sel;
    sel = $urandom_range(0, 2);
    alct_vpf  = r & (sel == 0);
    clct_vpf  = r & (sel == 1);
    copad_vpf = r & (sel == 2);
    gem_vpf   = 1'($urandom_range(0, 1));
  endtask

  task automatic run_window(input logic bend, input int hold_cycles, input int drop_mode,
                            input int rst_hold);
    int         last;
    logic       oa, oc, og, op, r;
    logic [4:0] ef;
    logic [2:0] eq;
`ifdef GEMCSC_EARLY_CLOSE_EN
    logic ca, cc, cp;
`endif
    last = MXWIN - 1;
`ifdef GEMCSC_EARLY_CLOSE_EN
    ca = bx_a[0]; cc = bx_c[0]; cp = bx_p[0];
    for (int k = 1; k < MXWIN; k++) begin
      ca |= bx_a[k]; cc |= bx_c[k]; cp |= bx_p[k];
      if (ca && cc && cp) begin
        last = k;
        break;
      end
    end
`endif
    oa = 1'b0; oc = 1'b0; og = 1'b0; op = 1'b0;
    for (int k = 0; k <= last; k++) begin
      alct_vpf = bx_a[k]; clct_vpf = bx_c[k]; gem_vpf = bx_g[k]; copad_vpf = bx_p[k];
      lct_ack = 1'($urandom_range(0, 1));
      gemcsc_bend_enable = 1'($urandom_range(0, 1));
      oa |= bx_a[k]; oc |= bx_c[k]; og |= bx_g[k]; op |= bx_p[k];
      step();
      chk("open_busy", 32'(seq_busy), 32'd1);
      chk("open_vpf", 32'(lct_vpf), 32'd0);
    end

    r = (drop_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    drop_inputs(r);
    lct_ack = 1'($urandom_range(0, 1));
    gemcsc_bend_enable = bend;
    step();
    if (r) exp_drop++;
    ef = {oa & oc & op, oa & oc & og, oa & oc, oc & op, oa & op};
    eq = ref_q(oa, oc, og, op, bend);
    chk("res_vpf", 32'(lct_vpf), 32'(eq != 3'd0));
    chk("res_q", 32'(lct_q), 32'(eq));
    chk("res_flags", 32'(match_flags), 32'((eq != 3'd0) ? ef : 5'd0));
    chk_drops("res");
    if (eq == 3'd0) begin
      chk("noq_busy", 32'(seq_busy), 32'd0);
      idle_inputs();
      return;
    end

    for (int i = 0; i < hold_cycles; i++) begin
      r = (drop_mode == 2) ? 1'b1 : (drop_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      drop_inputs(r);
      lct_ack = 1'b0;
      gemcsc_bend_enable = 1'($urandom_range(0, 1));
      step();
      if (r) exp_drop++;
      chk("hold_vpf", 32'(lct_vpf), 32'd1);
      chk("hold_q", 32'(lct_q), 32'(eq));
      chk("hold_flags", 32'(match_flags), 32'(ef));
      chk_drops("hold");
      if (i == rst_hold) begin
        reset_n = 1'b0;
        #1;
        chk_all_zero("rst_hold");
        exp_drop = 0;
        idle_inputs();
        #2 reset_n = 1'b1;
        return;
      end
    end

    r = (drop_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    drop_inputs(r);
    lct_ack = 1'b1;
    step();
    if (r) exp_drop++;
    chk("ack_vpf", 32'(lct_vpf), 32'd0);
    chk("ack_busy", 32'(seq_busy), 32'd0);
    chk("ack_flags", 32'(match_flags), 32'd0);
    chk_drops("ack");
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    step();
    step();
    chk_all_zero("reset");
    reset_n = 1'b1;
    step();

    // GEM alone never opens a window; ack in IDLE is ignored
    gem_vpf = 1'b1;
    lct_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("gem_only_busy", 32'(seq_busy), 32'd0);
      chk("gem_only_vpf", 32'(lct_vpf), 32'd0);
    end
    idle_inputs();
    step();

    // alct t0, clct t0+2, copad (+gem) t0+5, bend=1 -> q 7, all flags
    clear_bx();
    bx_a[0] = 1'b1; bx_c[2] = 1'b1; bx_p[5] = 1'b1; bx_g[5] = 1'b1;
    run_window(1'b1, 2, 0, -1);

    // clct t0, gem t0+3, alct t0+6, bend=0 -> q 4, flags 01100
    clear_bx();
    bx_c[0] = 1'b1; bx_g[3] = 1'b1; bx_a[6] = 1'b1;
    run_window(1'b0, 1, 0, -1);

    clear_bx();
    bx_c[0] = 1'b1; bx_p[4] = 1'b1;
    run_window(1'b1, 0, 0, -1);

    clear_bx();
    bx_a[0] = 1'b1; bx_p[3] = 1'b1;
    run_window(1'b1, 1, 0, -1);

    // clct alone resolves to nothing; no drops so far
    clear_bx();
    bx_c[0] = 1'b1;
    run_window(1'b1, 0, 0, -1);

    // 20 pending cycles with a trigger each cycle
    clear_bx();
    bx_a[0] = 1'b1; bx_c[1] = 1'b1;
    run_window(1'b1, 20, 2, -1);

    // everything at t0
    clear_bx();
    bx_a[0] = 1'b1; bx_c[0] = 1'b1; bx_p[0] = 1'b1;
    run_window(1'b1, 1, 0, -1);

    // reset in the middle of an open window
    alct_vpf = 1'b1;
    step();
    chk("rst_win_busy", 32'(seq_busy), 32'd1);
    alct_vpf = 1'b0;
    clct_vpf = 1'b1;
    for (int i = 0; i < 3; i++) step();
    clct_vpf = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_all_zero("rst_win");
    exp_drop = 0;
    #2 reset_n = 1'b1;
    step();
    chk("post_rst_busy", 32'(seq_busy), 32'd0);
    clear_bx();
    bx_c[0] = 1'b1; bx_p[2] = 1'b1;
    run_window(1'b1, 2, 1, -1);

    // reset on the third HOLD cycle, then a fresh window
    clear_bx();
    bx_a[0] = 1'b1; bx_c[0] = 1'b1;
    run_window(1'b1, 5, 1, 2);
    step();
    clear_bx();
    bx_a[0] = 1'b1; bx_p[1] = 1'b1;
    run_window(1'b0, 1, 1, -1);

    for (int n = 0; n < 30; n++) begin
      clear_bx();
      for (int k = 0; k < MXWIN; k++) begin
        bx_a[k] = ($urandom_range(0, 3) == 0);
        bx_c[k] = ($urandom_range(0, 3) == 0);
        bx_g[k] = ($urandom_range(0, 3) == 0);
        bx_p[k] = ($urandom_range(0, 4) == 0);
      end
      if (!(bx_a[0] || bx_c[0] || bx_p[0])) begin
        case ($urandom_range(0, 2))
          0:       bx_a[0] = 1'b1;
          1:       bx_c[0] = 1'b1;
          default: bx_p[0] = 1'b1;
        endcase
      end
      run_window(1'($urandom_range(0, 1)), $urandom_range(0, 4), 1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gemcsc_match_sequencer.md
Name: gemcsc_match_sequencer

Overview:
- Sequences GEM-CSC LCT building for one chamber.
- A trigger (ALCT, CLCT or GEM copad) opens a match window of MXWIN bx. During the window, ALCT/CLCT/GEM/copad presence flags accumulate as sticky bits.
- When the window closes, the block resolves the match class and the 3-bit LCT quality, then holds the result under a valid/ack handshake to the LCT builder.
- Triggers that arrive while a result is resolving or pending are dropped and counted.

Parameters:
- MXWIN, 7, match-window length in bx (legal range 1..15).
- MXDROPB, 8, width of the saturating dropped-trigger counter.

Ports:
- clock  in  1  40 MHz main clock
- reset_n  in  1  asynchronous active-low reset
- alct_vpf  in  1  ALCT valid this bx
- clct_vpf  in  1  CLCT valid this bx
- gem_vpf  in  1  any single-layer GEM cluster matched this bx
- copad_vpf  in  1  GEM copad matched this bx
- gemcsc_bend_enable  in  1  GEM-CSC bend check passed; sampled in RESOLVE
- lct_ack  in  1  downstream accepted the result
- lct_vpf  out  1  result valid
- lct_q  out  3  LCT quality
- match_flags  out  5  {alct_clct_copad, alct_clct_gem, alct_clct, clct_copad, alct_copad}
- seq_busy  out  1  state is not IDLE
- drop_cnt  out  MXDROPB  saturating count of dropped triggers

Behaviour:
- Definitions:
  - trig = alct_vpf | clct_vpf | copad_vpf (gem_vpf alone never opens a window).
  - Sticky flags: s_alct, s_clct, s_gem, s_copad.
- Reset (async, reset_n=0):
  - state=IDLE; all sticky flags=0; win_cnt=0.
  - lct_vpf=0, lct_q=0, match_flags=0, drop_cnt=0.
  - This applies mid-window and mid-HOLD. A pending result is discarded.
- IDLE:
  - If trig: load the sticky flags from the current inputs (gem included) and set win_cnt=1.
  - Next state is OPEN, or RESOLVE if MXWIN==1.
- OPEN:
  - Each cycle, OR the inputs into the sticky flags and increment win_cnt.
  - The cycle in which win_cnt==MXWIN-1 is the last sampled bx; the next state is RESOLVE.
  - Triggers inside OPEN extend nothing and are not counted as drops.
- RESOLVE (1 cycle): compute matches from the sticky flags.
  - alct_clct_copad = s_alct&s_clct&s_copad
  - alct_clct_gem = s_alct&s_clct&s_gem
  - alct_clct = s_alct&s_clct
  - clct_copad = s_clct&s_copad
  - alct_copad = s_alct&s_copad
- Quality priority (first hit wins), b = gemcsc_bend_enable:
  - acc&b -> 7; acc&!b -> 6
  - acg&b -> 5; acg&!b -> 4
  - alct_clct -> 3
  - clct_copad -> 1
  - alct_copad -> 2
  - else 0
- RESOLVE outcome:
  - Q!=0: register lct_q and match_flags, set lct_vpf=1, go to HOLD.
  - Q==0: lct_vpf stays 0, clear the flags, go to IDLE.
- HOLD:
  - lct_vpf, lct_q and match_flags are held stable.
  - When lct_ack is sampled high: lct_vpf=0, flags cleared, state IDLE on the next edge.
  - lct_ack outside HOLD is ignored.
- Drops:
  - trig in RESOLVE or HOLD increments drop_cnt by 1 per cycle, saturating at all-ones.
  - trig on the same cycle that HOLD sees lct_ack is also dropped; no back-to-back reopen.
- Latency: trigger sampled at edge t0 -> lct_vpf high at edge t0+MXWIN.
- Outputs are all registered; there is no combinational path from inputs to outputs.
- seq_busy=(state!=IDLE).

Optional Feature:
- Macro: GEMCSC_EARLY_CLOSE_EN.
- When defined: in OPEN, as soon as (s_alct|alct_vpf)&(s_clct|clct_vpf)&(s_copad|copad_vpf) is true, go to RESOLVE on the next edge regardless of win_cnt. This is the best class reachable, so the latency shortens.
- When undefined: the window always runs to full MXWIN bx.
- All other behaviour is identical in both builds.

Decomposition:
- Package gemcsc_seq_pkg holds:
  - state encodings IDLE/OPEN/RESOLVE/HOLD (2-bit);
  - quality constants Q_ACC_BEND=7, Q_ACC=6, Q_ACG_BEND=5, Q_ACG=4, Q_AC=3, Q_CC=1, Q_AC2=2, Q_NONE=0;
  - match_flags bit indices.
- Sub-module gemcsc_quality_encode: a purely combinational priority encoder from the 5 match bits plus bend enable to Q. It is instantiated once in RESOLVE and is reusable by the LCT builder.

Test Plan:
- MXWIN=7: alct_vpf at t0, clct_vpf at t0+2, copad_vpf at t0+5, bend=1 in RESOLVE -> lct_vpf at t0+7, lct_q=7, match_flags=5'b11111.
- clct_vpf at t0, gem_vpf at t0+3, alct_vpf at t0+6, bend=0 -> lct_q=4, flags=5'b01100. Then clct+copad only in a new window -> lct_q=1; alct+copad only -> lct_q=2.
- clct_vpf only, no other hits in the window -> no lct_vpf, seq_busy drops at t0+7, drop_cnt=0.
- Result pending with lct_ack held low for 20 cycles, alct_vpf pulsing every cycle -> lct_vpf/lct_q stable, drop_cnt=20. With MXDROPB=4 and 20 drops -> drop_cnt=15.
- reset_n pulsed low at t0+4 of an open window and at the 3rd HOLD cycle -> all outputs 0 immediately, state IDLE, and the next trigger opens a fresh window.
- GEMCSC_EARLY_CLOSE_EN defined: alct, clct and copad all at t0 -> lct_vpf at t0+2, lct_q=7 (bend=1). Undefined: the same stimulus gives lct_vpf at t0+7.
